// File: rtl/seq_sub_pkg.sv
// rtl/seq_sub_pkg.sv - shared types and constants for the sliced sequential subtractor
package seq_sub_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SLICE = 8;

  // A single-slice configuration still needs a one-bit index register.
  function automatic int idx_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

// File: rtl/seq_sub_ctrl_if.sv
// rtl/seq_sub_ctrl_if.sv - operand request / result handshake bundle
interface seq_sub_ctrl_if
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_bout;
  logic             out_zero;
  logic             out_ovf;
  logic             busy;

  modport master (
    output in_valid, in_a, in_b, in_bin, out_ready,
    input  in_ready, out_valid, out_diff, out_bout, out_zero, out_ovf, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_bin, out_ready,
    output in_ready, out_valid, out_diff, out_bout, out_zero, out_ovf, busy
  );

endinterface

// File: rtl/sub_slice.sv
// rtl/sub_slice.sv - combinational SLICE-bit subtract with borrow in/out
module sub_slice
  import seq_sub_pkg::*;
#(
  parameter int SLICE = DEF_SLICE
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic             bin_i,
  output logic [SLICE-1:0] diff_o,
  output logic             bout_o
);

  // The extra top bit of the widened difference is exactly the unsigned borrow.
  assign {bout_o, diff_o} = {1'b0, a_i} - {1'b0, b_i} - (SLICE + 1)'(bin_i);

endmodule

// File: rtl/seq_sub_ctrl.sv
// rtl/seq_sub_ctrl.sv - WIDTH-bit subtract sequenced LSB-slice-first through one shared slice
module seq_sub_ctrl
  import seq_sub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SLICE = DEF_SLICE
) (
  input  logic          clk,
  input  logic          rst,
  seq_sub_ctrl_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = idx_width(NSLICE);

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             borrow_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             zero_q;
  logic             ovf_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE-1:0] diff_s;
  logic             bout_s;
  logic [WIDTH-1:0] res_d;
  logic             last_step;
  logic             ovf_d;

  assign a_s = a_q[idx_q*SLICE +: SLICE];
  assign b_s = b_q[idx_q*SLICE +: SLICE];

  sub_slice #(.SLICE(SLICE)) u_slice (
    .a_i    (a_s),
    .b_i    (b_s),
    .bin_i  (borrow_q),
    .diff_o (diff_s),
    .bout_o (bout_s)
  );

  // Working result with the current slice merged in; on the last step this is the final difference.
  always_comb begin
    res_d = res_q;
    res_d[idx_q*SLICE +: SLICE] = diff_s;
  end

  assign last_step = (idx_q == IDX_W'(NSLICE - 1));
  assign ovf_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      borrow_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
            borrow_q   <= bus.in_bin;
            idx_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          res_q    <= res_d;
          borrow_q <= bout_s;
          if (last_step) begin
            // Visible outputs only move here, so they persist through IDLE until the next result.
            diff_q      <= res_d;
            bout_q      <= bout_s;
            zero_q      <= (res_d == '0);
            ovf_q       <= ovf_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_diff  = diff_q;
  assign bus.out_bout  = bout_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: doc/seq_sub_ctrl.md
Name: seq_sub_ctrl

Overview:
- Multi-cycle controller that performs a WIDTH-bit subtraction by sequencing one shared SLICE-bit subtract slice, least-significant slice first.
- The borrow is carried between slices in a register.
- Sits between the ALU operand registers and the result bus, with a valid/ready handshake on both sides.
- Trades latency for area compared with a full-width parallel-prefix subtractor.

Parameters:
- WIDTH, 32, operand and result width; must be an integer multiple of SLICE.
- SLICE, 8, width of the shared subtract slice.
- NSLICE, WIDTH/SLICE, number of slice steps (derived localparam, not overridable).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand request valid.
- in_ready  out  1  controller can accept operands.
- in_a  in  WIDTH  minuend.
- in_b  in  WIDTH  subtrahend.
- in_bin  in  1  borrow-in; result = A - B - bin.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_diff  out  WIDTH  difference, modulo 2^WIDTH.
- out_bout  out  1  borrow-out; 1 iff A < B + bin (unsigned).
- out_zero  out  1  out_diff == 0.
- out_ovf  out  1  signed overflow: A[msb] != B[msb] and diff[msb] != A[msb].
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; slice index=0; borrow register=0; operand and result registers=0.
  - in_ready=1; out_valid=0; out_diff=0; out_bout=0; out_zero=0; out_ovf=0; busy=0.
  - Reset overrides every other input in the same cycle.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at an edge: capture in_a, in_b, in_bin; index<=0; borrow<=in_bin; go to RUN.
  - in_valid=0: stay in IDLE.
- RUN:
  - in_ready=0.
  - Each cycle, the slice computes a[idx], b[idx] and borrow into {bout_s, diff_s}, with diff_s = a_s - b_s - borrow (mod 2^SLICE) and bout_s = (a_s < b_s + borrow).
  - diff_s is written to result bits [idx*SLICE +: SLICE]; borrow<=bout_s.
  - idx < NSLICE-1: idx<=idx+1.
  - idx == NSLICE-1: go to DONE and register out_bout, out_zero, out_ovf from the final result.
- DONE:
  - out_valid=1; outputs are held stable while out_ready=0.
  - When out_ready=1 at an edge: out_valid<=0 and go to IDLE.
  - in_ready=0 throughout DONE; in_valid is ignored.
- Latency: out_valid rises NSLICE edges after the accepting edge (4 for the defaults).
- Throughput: at most one operation per NSLICE+2 cycles; no overlap between operations.
- Flag outputs: out_diff and the flags change only on the RUN→DONE transition. They keep their last values in IDLE until the next DONE; this holds after the first completed operation, and they are 0 after reset.
- Borrow is unsigned throughout; out_ovf is computed from the captured operands, not from the input ports.
- Input stability: in_a, in_b and in_bin may change freely after capture. Changes to the input ports outside the accepting edge have no effect.
- Reset mid-operation (RUN or DONE): the operation is discarded; the next cycle is IDLE with reset values; no out_valid is produced for the aborted operation.
- Back-to-back: after the DONE handshake edge, the earliest next acceptance is the following edge (IDLE lasts at least one cycle).
- Borrow ripple: a borrow generated in slice 0 propagates through all slices (e.g. 0 - 1) with no extra cycles.

Decomposition:
- Shared package seq_sub_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default WIDTH/SLICE constants;
  - index width $clog2(NSLICE).
- One sub-module, sub_slice: a combinational SLICE-bit subtract with borrow (a, b, bin → diff, bout), instantiated once.
- The controller owns the FSM, index counter, borrow register, operand/result registers and flag logic.

Test Plan:
- A=0x00000005, B=0x00000003, bin=0 → diff=0x00000002, bout=0, zero=0, ovf=0; out_valid exactly 4 edges after acceptance.
- A=0x00000000, B=0x00000001, bin=0 → diff=0xFFFFFFFF, bout=1, zero=0, ovf=0 (full borrow ripple).
- A=0x12345678, B=0x12345677, bin=1 → diff=0x00000000, bout=0, zero=1.
- A=0x80000000, B=0x00000001, bin=0 → diff=0x7FFFFFFF, ovf=1, bout=0; then A=0x7FFFFFFF, B=0xFFFFFFFF → diff=0x80000000, ovf=1, bout=1.
- Hold out_ready=0 for 5 cycles in DONE while toggling in_valid and the operand inputs → outputs stable, in_ready=0, no capture. Raise out_ready → out_valid=0 and in_ready=1 on the next cycle.
- Assert rst for one cycle during RUN at idx=2 → next cycle IDLE with all outputs at reset values, no out_valid. A following op A=10, B=20 → diff=0xFFFFFFF6, bout=1.
